// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential divider.
// Holds the FSM state enum and the iteration counter width.
package div_pkg;

   localparam int DIV_N  = 8;
   localparam int DIV_CW = $clog2(DIV_N);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ITER,
      FIX,
      DONE
   } div_state_t;

endpackage

// File: rtl/Sub_n.sv
// Sub_n: n-bit trial subtractor, diff_o = a_i - b_i.
// Ports: clk_i/rst_ni (carry-in register), sign_i (signed MSB), a_i, b_i, diff_o.
module Sub_n #(
   parameter int n = 9
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         sign_i,
   input  logic [n-1:0] a_i,
   input  logic [n-1:0] b_i,
   output logic [n-1:0] diff_o
);

   logic         r_cin;
   logic [n-1:0] w_raw;
   logic         w_ovf;

   // Carry-in for a + ~b + 1; settles to 1 on the first edge after reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_cin <= 1'b0;
      else         r_cin <= 1'b1;
   end

   assign w_raw = a_i + ~b_i + {{(n-1){1'b0}}, r_cin};

   // In signed mode the MSB reports the true sign even on overflow.
   assign w_ovf  = (a_i[n-1] ^ b_i[n-1]) & (w_raw[n-1] ^ a_i[n-1]);
   assign diff_o = {w_raw[n-1] ^ (sign_i & w_ovf), w_raw[n-2:0]};

endmodule

// File: rtl/div_seq_n.sv
// div_seq_n: iterative restoring divider, unsigned or signed, N+2 cycle latency.
// Ports: clk_i, rst_ni, start_i/ready_o, sign_i, dividend_i, divisor_i,
//        valid_o/ready_i, quot_o, rem_o, div0_o, ovf_o.
module div_seq_n
   import div_pkg::*;
#(
   parameter int N = DIV_N
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         start_i,
   output logic         ready_o,
   input  logic         sign_i,
   input  logic [N-1:0] dividend_i,
   input  logic [N-1:0] divisor_i,
   output logic         valid_o,
   input  logic         ready_i,
   output logic [N-1:0] quot_o,
   output logic [N-1:0] rem_o,
   output logic         div0_o,
   output logic         ovf_o
);

   localparam int CW = (N == DIV_N) ? DIV_CW : $clog2(N);

   div_state_t   r_state;
   logic [CW-1:0] r_cnt;
   logic [N-1:0] r_a;
   logic [N-1:0] r_bin;
   logic         r_sign;
   logic [N-1:0] r_q;
   logic [N-1:0] r_b;
   logic [N-1:0] r_rem;
   logic         r_qneg;
   logic         r_rneg;
   logic         r_div0;
   logic         r_ready;
   logic         r_valid;
   logic [N-1:0] r_quot_o;
   logic [N-1:0] r_rem_o;
   logic         r_div0_o;
   logic         r_ovf_o;

   logic [N:0]   w_t;
   logic [N:0]   w_diff;
   logic         w_neg;
   logic         w_ovf;

   // r_q shifts dividend bits out of the top and quotient bits in at the bottom.
   assign w_t   = {r_rem, r_q[N-1]};
   assign w_neg = w_diff[N];
   assign w_ovf = r_sign && (r_a == {1'b1, {(N-1){1'b0}}}) && (r_bin == '1);

   Sub_n #(.n(N+1)) u_sub (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .sign_i (1'b0),
      .a_i    (w_t),
      .b_i    ({1'b0, r_b}),
      .diff_o (w_diff)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_a      <= '0;
         r_bin    <= '0;
         r_sign   <= 1'b0;
         r_q      <= '0;
         r_b      <= '0;
         r_rem    <= '0;
         r_qneg   <= 1'b0;
         r_rneg   <= 1'b0;
         r_div0   <= 1'b0;
         r_ready  <= 1'b1;
         r_valid  <= 1'b0;
         r_quot_o <= '0;
         r_rem_o  <= '0;
         r_div0_o <= 1'b0;
         r_ovf_o  <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (start_i) begin
                  r_a     <= dividend_i;
                  r_bin   <= divisor_i;
                  r_sign  <= sign_i;
                  r_ready <= 1'b0;
                  r_state <= LOAD;
               end
            end
            LOAD: begin
               r_q     <= (r_sign && r_a[N-1]) ? -r_a : r_a;
               r_b     <= (r_sign && r_bin[N-1]) ? -r_bin : r_bin;
               r_rem   <= '0;
               r_qneg  <= r_sign & (r_a[N-1] ^ r_bin[N-1]);
               r_rneg  <= r_sign & r_a[N-1];
               r_div0  <= (r_bin == '0);
               r_cnt   <= CW'(N-1);
               r_state <= ITER;
            end
            ITER: begin
               r_rem <= w_neg ? w_t[N-1:0] : w_diff[N-1:0];
               r_q   <= {r_q[N-2:0], ~w_neg};
               if (r_cnt == '0) r_state <= FIX;
               else             r_cnt   <= r_cnt - 1'b1;
            end
            FIX: begin
               if (r_div0) begin
                  r_quot_o <= '1;
                  r_rem_o  <= r_a;
               end else begin
                  r_quot_o <= r_qneg ? -r_q : r_q;
                  r_rem_o  <= r_rneg ? -r_rem : r_rem;
               end
               r_div0_o <= r_div0;
               r_ovf_o  <= w_ovf;
               r_valid  <= 1'b1;
               r_state  <= DONE;
            end
            DONE: begin
               if (ready_i) begin
                  r_valid <= 1'b0;
                  r_ready <= 1'b1;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_ready <= 1'b1;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign ready_o = r_ready;
   assign valid_o = r_valid;
   assign quot_o  = r_quot_o;
   assign rem_o   = r_rem_o;
   assign div0_o  = r_div0_o;
   assign ovf_o   = r_ovf_o;

endmodule

// File: tb/tb_div_seq_n.sv
// Scoreboard bench for div_seq_n (N=8) with directed hand-computed vectors.
// Stimulus pushes expectations; a negedge monitor pops on each accepted result.
module tb_div_seq_n;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       start_i;
   logic       ready_o;
   logic       sign_i;
   logic [7:0] dividend_i;
   logic [7:0] divisor_i;
   logic       valid_o;
   logic       ready_i;
   logic [7:0] quot_o;
   logic [7:0] rem_o;
   logic       div0_o;
   logic       ovf_o;

   typedef struct {
      logic [7:0] q;
      logic [7:0] r;
      logic       d0;
      logic       ov;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_issued = 0;
   int   n_results = 0;

   always #5 clk_i = ~clk_i;

   div_seq_n #(.N(8)) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .start_i    (start_i),
      .ready_o    (ready_o),
      .sign_i     (sign_i),
      .dividend_i (dividend_i),
      .divisor_i  (divisor_i),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .quot_o     (quot_o),
      .rem_o      (rem_o),
      .div0_o     (div0_o),
      .ovf_o      (ovf_o)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: compare each result at the cycle the consumer takes it.
   always @(negedge clk_i) begin
      if (rst_ni && valid_o && ready_i) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: got q=0x%0h with empty scoreboard",
                     quot_o);
         end else begin
            exp_t e;
            e = sb.pop_front();
            n_results++;
            chk("quot", {24'd0, quot_o}, {24'd0, e.q});
            chk("rem",  {24'd0, rem_o},  {24'd0, e.r});
            chk("div0", {31'd0, div0_o}, {31'd0, e.d0});
            chk("ovf",  {31'd0, ovf_o},  {31'd0, e.ov});
         end
      end
   end

   task automatic wait_ready();
      int t;
      t = 0;
      while (!ready_o && t < 50) begin
         @(posedge clk_i); #1;
         t++;
      end
      chk("ready_wait", {31'd0, ready_o}, 32'd1);
   endtask

   task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                         input logic s, input logic [7:0] eq,
                         input logic [7:0] er, input logic ed,
                         input logic eo, input int hold,
                         input bit pulse);
      int lat;
      exp_t e;
      wait_ready();
      e.q = eq; e.r = er; e.d0 = ed; e.ov = eo;
      sb.push_back(e);
      n_issued++;
      ready_i    = (hold == 0);
      dividend_i = a;
      divisor_i  = b;
      sign_i     = s;
      start_i    = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      dividend_i = 8'h11;
      divisor_i  = 8'h01;
      lat = 0;
      while (!valid_o && lat < 40) begin
         start_i = pulse && (lat == 4);
         @(posedge clk_i); #1;
         lat++;
      end
      start_i = 1'b0;
      chk("latency", lat, 32'd10);
      if (hold > 0) begin
         for (int i = 0; i < hold; i++) begin
            start_i = pulse && (i == 0);
            @(posedge clk_i); #1;
            start_i = 1'b0;
            chk("hold_valid", {31'd0, valid_o}, 32'd1);
            chk("hold_quot",  {24'd0, quot_o},  {24'd0, eq});
            chk("hold_rem",   {24'd0, rem_o},   {24'd0, er});
         end
         ready_i = 1'b1;
      end
      @(posedge clk_i); #1;
      chk("after_valid", {31'd0, valid_o}, 32'd0);
      chk("after_quot",  {24'd0, quot_o},  {24'd0, eq});
   endtask

   initial begin
      rst_ni     = 1'b0;
      start_i    = 1'b0;
      sign_i     = 1'b0;
      dividend_i = '0;
      divisor_i  = '0;
      ready_i    = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_ready", {31'd0, ready_o}, 32'd1);
      chk("rst_valid", {31'd0, valid_o}, 32'd0);
      chk("rst_quot",  {24'd0, quot_o},  32'd0);
      chk("rst_rem",   {24'd0, rem_o},   32'd0);
      chk("rst_div0",  {31'd0, div0_o},  32'd0);
      chk("rst_ovf",   {31'd0, ovf_o},   32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i); #1;

      run_op(8'd200, 8'd7,  1'b0, 8'd28,  8'd4,  1'b0, 1'b0, 0, 1'b0);
      run_op(8'hF9,  8'h02, 1'b1, 8'hFD,  8'hFF, 1'b0, 1'b0, 0, 1'b0);
      run_op(8'h55,  8'h00, 1'b0, 8'hFF,  8'h55, 1'b1, 1'b0, 0, 1'b0);
      run_op(8'h55,  8'h00, 1'b1, 8'hFF,  8'h55, 1'b1, 1'b0, 0, 1'b0);
      run_op(8'h80,  8'hFF, 1'b1, 8'h80,  8'h00, 1'b0, 1'b1, 0, 1'b0);
      run_op(8'h80,  8'hFF, 1'b0, 8'h00,  8'h80, 1'b0, 1'b0, 0, 1'b0);
      run_op(8'd100, 8'hF9, 1'b1, 8'hF2,  8'h02, 1'b0, 1'b0, 0, 1'b0);
      run_op(8'hFF,  8'h10, 1'b0, 8'h0F,  8'h0F, 1'b0, 1'b0, 5, 1'b1);

      // Abort an operation mid-iteration with reset.
      wait_ready();
      dividend_i = 8'd200;
      divisor_i  = 8'd7;
      sign_i     = 1'b0;
      start_i    = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (5) begin
         @(posedge clk_i); #1;
      end
      rst_ni = 1'b0;
      #2;
      chk("abort_ready", {31'd0, ready_o}, 32'd1);
      chk("abort_valid", {31'd0, valid_o}, 32'd0);
      chk("abort_quot",  {24'd0, quot_o},  32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (12) begin
         @(posedge clk_i); #1;
         chk("abort_no_valid", {31'd0, valid_o}, 32'd0);
      end

      run_op(8'd100, 8'd9, 1'b0, 8'd11, 8'd1, 1'b0, 1'b0, 0, 1'b0);

      repeat (15) @(posedge clk_i);
      #1;
      chk("sb_empty", sb.size(), 32'd0);
      chk("result_count", n_results, n_issued);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
